// File: rtl/mac_job_ctrl.sv
// Dot-product job controller: buffers operand pairs and sequences an external MAC
// through clear/accumulate/drain, then holds the captured result until it is consumed.
module mac_job_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_last,
  output logic        mac_en,
  output logic        mac_clr,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  input  logic [23:0] mac_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_data,
  output logic [8:0]  res_len,
  output logic        res_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [16:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [16:0]        head_s;
  logic               mac_en_s;
  logic               mac_clr_s;
  logic [7:0]         mac_a_s;
  logic [7:0]         mac_b_s;
  logic [8:0]         pair_cnt_r;
  logic               ovf_r;
  logic [23:0]        res_data_r;
  logic [8:0]         res_len_r;
  logic               res_ovf_r;

  assign full_s   = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s  = (count_r == CNT_W'(0));
  assign push_s   = in_valid && !full_s;
  assign head_s   = mem_r[rd_ptr_r];

  assign in_ready  = !full_s;
  assign mac_en    = mac_en_s;
  assign mac_clr   = mac_clr_s;
  assign mac_a     = mac_a_s;
  assign mac_b     = mac_b_s;
  assign res_valid = (state_r == ST_RESULT);
  assign res_data  = res_data_r;
  assign res_len   = res_len_r;
  assign res_ovf   = res_ovf_r;

  // FIFO storage, entry layout {last, a, b}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 17'd0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {in_last, in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally for power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and MAC drive; the MAC sees the head pair in the same cycle it is popped
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    mac_en_s  = 1'b0;
    mac_clr_s = 1'b0;
    mac_a_s   = 8'd0;
    mac_b_s   = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        mac_clr_s = 1'b1;
        state_s   = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          mac_en_s = 1'b1;
          mac_a_s  = head_s[15:8];
          mac_b_s  = head_s[7:0];
          if (head_s[16]) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        state_s = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Pair counter saturates at 511; overflow is sticky once the job passes 256 pairs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt_r <= 9'd0;
      ovf_r      <= 1'b0;
    end else if (state_r == ST_CLEAR) begin
      pair_cnt_r <= 9'd0;
      ovf_r      <= 1'b0;
    end else if (pop_s) begin
      if (pair_cnt_r != 9'd511) begin
        pair_cnt_r <= pair_cnt_r + 9'd1;
      end
      if (pair_cnt_r >= 9'd256) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Result capture: mac_cout already reflects the final pair during DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_r <= 24'd0;
      res_len_r  <= 9'd0;
      res_ovf_r  <= 1'b0;
    end else if (state_r == ST_DRAIN) begin
      res_data_r <= mac_cout;
      res_len_r  <= pair_cnt_r;
      res_ovf_r  <= ovf_r;
    end
  end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Self-checking bench for mac_job_ctrl: behavioural MAC, result monitor and
// a sum-of-products reference model for each job.
module tb_mac_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        mac_en;
  logic        mac_clr;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [23:0] mac_cout;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic [8:0]  res_len;
  logic        res_ovf;

  int checks = 0;
  int errors = 0;

  mac_job_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_len(res_len), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural MAC datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_cout <= 24'd0;
    else if (mac_clr) mac_cout <= 24'd0;
    else if (mac_en) mac_cout <= mac_cout + ({16'd0, mac_a} * {16'd0, mac_b});
  end

  // Monitor: counts MAC activity, protocol violations, and records each accepted result
  int          cyc = 0;
  int          en_total = 0;
  int          clr_total = 0;
  int          viol = 0;
  int          clr_cyc = 0;
  int          res_wr = 0;
  int          lat_wr = 0;
  logic        prev_rv = 1'b0;
  logic [23:0] rec_d [64];
  logic [8:0]  rec_l [64];
  logic        rec_o [64];
  int          rec_lat [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mac_en) en_total <= en_total + 1;
    if (mac_clr) begin
      clr_total <= clr_total + 1;
      clr_cyc   <= cyc;
    end
    if ((mac_en && mac_clr) || (!mac_en && (mac_a != 8'd0 || mac_b != 8'd0))) viol <= viol + 1;
    if (res_valid && !prev_rv && lat_wr < 64) begin
      rec_lat[lat_wr] <= cyc - clr_cyc;
      lat_wr <= lat_wr + 1;
    end
    if (res_valid && res_ready && res_wr < 64) begin
      rec_d[res_wr] <= res_data;
      rec_l[res_wr] <= res_len;
      rec_o[res_wr] <= res_ovf;
      res_wr <= res_wr + 1;
    end
    prev_rv <= res_valid;
  end

  logic [7:0] job_a[$];
  logic [7:0] job_b[$];
  int rd_idx = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
    int w;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 3000) begin
      step();
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0; in_a = 8'd0; in_b = 8'd0;
  endtask

  // Reference model: plain sum of products over the job
  function automatic logic [23:0] model_sum();
    longint s = 0;
    foreach (job_a[i]) s += longint'(job_a[i]) * longint'(job_b[i]);
    return s[23:0];
  endfunction

  function automatic logic [8:0] model_len();
    return (job_a.size() > 511) ? 9'd511 : 9'(job_a.size());
  endfunction

  // Pushes the current job (gap<0: random 0..2 idle cycles) and fetches its result
  task automatic run_job(input int gap, output logic [23:0] d, output logic [8:0] l,
                         output logic o, output int lat, output int en_d, output int clr_d);
    int en0, clr0, w, n;
    en0 = en_total; clr0 = clr_total; n = job_a.size();
    for (int i = 0; i < n; i++) begin
      push(job_a[i], job_b[i], (i == n - 1));
      if (i < n - 1) begin
        if (gap < 0) repeat ($urandom_range(2, 0)) step();
        else repeat (gap) step();
      end
    end
    w = 0;
    while (res_wr <= rd_idx && w < 3000) begin
      step();
      w++;
    end
    if (res_wr > rd_idx) begin
      d = rec_d[rd_idx]; l = rec_l[rd_idx]; o = rec_o[rd_idx]; lat = rec_lat[rd_idx];
      rd_idx++;
    end else begin
      checks++; errors++;
      $display("FAIL result_timeout: no result after %0d cycles", w);
      d = {24{1'bx}}; l = {9{1'bx}}; o = 1'bx; lat = -1;
    end
    en_d = en_total - en0;
    clr_d = clr_total - clr0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    checks++; if (mac_en !== 1'b0 || mac_clr !== 1'b0) begin errors++; $display("FAIL reset_mac_ctl: got en=%b clr=%b required 0 0", mac_en, mac_clr); end
    checks++; if (res_data !== 24'd0 || res_len !== 9'd0 || res_ovf !== 1'b0) begin errors++; $display("FAIL reset_result: got %0d/%0d/%b required 0/0/0", res_data, res_len, res_ovf); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    logic [23:0] d; logic [8:0] l; logic o; int lat, en_d, clr_d;
    res_ready = 1'b1;
    job_a = '{8'd2, 8'd4, 8'd10}; job_b = '{8'd3, 8'd5, 8'd10};
    run_job(0, d, l, o, lat, en_d, clr_d);
    checks++; if (d !== 24'd126) begin errors++; $display("FAIL basic_data: got %0d required 126", d); end
    checks++; if (l !== 9'd3) begin errors++; $display("FAIL basic_len: got %0d required 3", l); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b required 0", o); end
    checks++; if (clr_d != 1) begin errors++; $display("FAIL basic_clr_pulses: got %0d required 1", clr_d); end
    checks++; if (en_d != 3) begin errors++; $display("FAIL basic_en_cycles: got %0d required 3", en_d); end
    // CLEAR is cycle 1, so res_valid appears N+2 cycles after the clear cycle
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d required 5", lat); end
  endtask

  task automatic test_gaps();
    logic [23:0] d0, d1; logic [8:0] l0, l1; logic o0, o1; int lat0, lat1, en0, en1, c0, c1;
    res_ready = 1'b1;
    job_a = '{8'd3, 8'd9, 8'd5, 8'd1}; job_b = '{8'd7, 8'd2, 8'd5, 8'd8};
    run_job(0, d0, l0, o0, lat0, en0, c0);
    run_job(2, d1, l1, o1, lat1, en1, c1);
    checks++; if (d0 !== 24'd72) begin errors++; $display("FAIL gap_free_data: got %0d required 72", d0); end
    checks++; if (d1 !== d0 || l1 !== 9'd4) begin errors++; $display("FAIL gap_data: got %0d/%0d required %0d/4", d1, l1, d0); end
    checks++; if (en1 != 4) begin errors++; $display("FAIL gap_en_cycles: got %0d required 4", en1); end
    checks++; if (lat1 <= lat0) begin errors++; $display("FAIL gap_bubbles: got latency %0d required more than %0d", lat1, lat0); end
  endtask

  task automatic test_random();
    logic [23:0] d, ed; logic [8:0] l; logic o; int lat, en_d, clr_d, n;
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(12, 1);
      job_a.delete(); job_b.delete();
      for (int i = 0; i < n; i++) begin
        job_a.push_back(8'($urandom_range(255, 0)));
        job_b.push_back(8'($urandom_range(255, 0)));
      end
      ed = model_sum();
      run_job(-1, d, l, o, lat, en_d, clr_d);
      checks++;
      if (d !== ed || l !== model_len() || o !== 1'b0 || en_d != n) begin
        errors++;
        $display("FAIL random_job%0d: got data=%0d len=%0d ovf=%b en=%0d required data=%0d len=%0d ovf=0 en=%0d",
                 j, d, l, o, en_d, ed, model_len(), n);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] d, ed; logic [8:0] l; logic o; int w;
    res_ready = 1'b0;
    push(8'd7, 8'd6, 1'b1);
    w = 0;
    while (!res_valid && w < 50) begin step(); w++; end
    checks++; if (res_valid !== 1'b1 || res_data !== 24'd42) begin errors++; $display("FAIL stall_first: got valid=%b data=%0d required 1 42", res_valid, res_data); end
    job_a.delete(); job_b.delete();
    for (int i = 0; i < 9; i++) begin
      job_a.push_back(8'($urandom_range(255, 0)));
      job_b.push_back(8'($urandom_range(255, 0)));
    end
    ed = model_sum();
    for (int i = 0; i < 8; i++) begin
      push(job_a[i], job_b[i], 1'b0);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 24'd42) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b data=%0d required 1 42", i, res_valid, res_data);
      end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got in_ready=%b required 0", in_ready); end
    res_ready = 1'b1;
    push(job_a[8], job_b[8], 1'b1);
    w = 0;
    while (res_wr < rd_idx + 2 && w < 100) begin step(); w++; end
    if (res_wr >= rd_idx + 2) begin
      checks++; if (rec_d[rd_idx] !== 24'd42 || rec_l[rd_idx] !== 9'd1) begin errors++; $display("FAIL stall_result1: got %0d/%0d required 42/1", rec_d[rd_idx], rec_l[rd_idx]); end
      d = rec_d[rd_idx + 1]; l = rec_l[rd_idx + 1]; o = rec_o[rd_idx + 1];
      checks++; if (d !== ed || l !== 9'd9 || o !== 1'b0) begin errors++; $display("FAIL stall_result2: got %0d/%0d/%b required %0d/9/0", d, l, o, ed); end
      checks++; if (rec_lat[rd_idx + 1] != 11) begin errors++; $display("FAIL stall_latency: got %0d required 11", rec_lat[rd_idx + 1]); end
      rd_idx += 2;
    end else begin
      checks++; errors++;
      $display("FAIL stall_timeout: got %0d results required %0d", res_wr - rd_idx, 2);
      rd_idx = res_wr;
    end
  endtask

  task automatic test_long();
    logic [23:0] d; logic [8:0] l; logic o; int lat, en_d, clr_d;
    res_ready = 1'b1;
    for (int k = 256; k <= 257; k++) begin
      job_a.delete(); job_b.delete();
      for (int i = 0; i < k; i++) begin
        job_a.push_back(8'd255);
        job_b.push_back(8'd255);
      end
      run_job(0, d, l, o, lat, en_d, clr_d);
      checks++;
      if (d !== model_sum() || l !== model_len() || o !== (k > 256)) begin
        errors++;
        $display("FAIL long_%0d: got data=%0d len=%0d ovf=%b required data=%0d len=%0d ovf=%b",
                 k, d, l, o, model_sum(), model_len(), (k > 256));
      end
    end
    checks++; if (model_sum() == 24'd0 || d !== 24'd16711425) begin errors++; $display("FAIL long_257_data: got %0d required 16711425", d); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] d; logic [8:0] l; logic o; int lat, en_d, clr_d, en0, w, res0;
    res_ready = 1'b1;
    res0 = res_wr; en0 = en_total;
    push(8'd1, 8'd2, 1'b0); push(8'd3, 8'd4, 1'b0); push(8'd5, 8'd6, 1'b0); push(8'd7, 8'd8, 1'b1);
    w = 0;
    while ((en_total - en0) < 2 && w < 50) begin step(); w++; end
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b1 || mac_en !== 1'b0 || mac_clr !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got rdy=%b en=%b clr=%b vld=%b required 1 0 0 0", in_ready, mac_en, mac_clr, res_valid); end
    checks++; if (res_data !== 24'd0 || res_len !== 9'd0) begin errors++; $display("FAIL midreset_result: got %0d/%0d required 0/0", res_data, res_len); end
    rst_n = 1'b1;
    repeat (12) step();
    checks++; if (res_wr != res0) begin errors++; $display("FAIL midreset_no_result: got %0d results required 0", res_wr - res0); end
    rd_idx = res_wr;
    job_a = '{8'd1}; job_b = '{8'd1};
    run_job(0, d, l, o, lat, en_d, clr_d);
    checks++; if (d !== 24'd1 || l !== 9'd1 || o !== 1'b0) begin errors++; $display("FAIL midreset_next_job: got %0d/%0d/%b required 1/1/0", d, l, o); end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL mac_protocol: got %0d violating cycles required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_random();
    test_stall();
    test_long();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
